dmem_sync: RTL and testbench
============================

# dmem_sync

Parametrised, clocked data memory for the datapath's load/store stage. Replaces the earlier combinational data RAM: one synchronous port with a valid/ready request handshake and a registered response. After reset, a hardware init sequence loads every word with its own index. Out-of-range and misaligned accesses are flagged, never silently aliased.

## Interface
- DATA_W, 32, word width in bits; multiple of 8
- DEPTH, 256, number of words; power of two, at least 2
- ADDR_W, 15, byte-address width; must satisfy 2^ADDR_W ≥ DEPTH·DATA_W/8
- clk  input  1  sole clock; all logic on the rising edge
- rst_n  input  1  reset, synchronous, active-low
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request this cycle
- req_write  input  1  1 = store, 0 = load
- data_address  input  ADDR_W  byte address
- write_data  input  DATA_W  store data
- byte_en  input  DATA_W/8  per-byte write strobe; only present with DMEM_BYTE_WRITE_EN
- rsp_valid  output  1  response pulse, one per accepted request
- rsp_err  output  1  accepted request was out of range or misaligned
- read_data  output  DATA_W  load result
- init_done  output  1  init sequence complete

## Operation
- OFF = log2(DATA_W/8). Word index = data_address[OFF+log2(DEPTH)-1 : OFF].
- Error conditions:
  - Misaligned: data_address[OFF-1:0] ≠ 0.
  - Out of range: any data_address bit at or above OFF+log2(DEPTH) is set.
- FSM states: INIT, RUN.
- INIT:
  - Entered from reset.
  - An internal counter i runs 0..DEPTH-1, writing mem[i] = i (zero-extended or truncated to DATA_W), one word per cycle.
  - req_ready = 0 and init_done = 0 throughout.
  - After writing word DEPTH-1, the FSM moves to RUN.
- RUN:
  - req_ready = 1 and init_done = 1.
  - A request is accepted when req_valid and req_ready are both 1.
- Accepted load, no error: the next cycle gives rsp_valid = 1, rsp_err = 0, read_data = mem[index].
- Accepted store, no error: mem[index] is written on the accept edge. The next cycle gives rsp_valid = 1, rsp_err = 0, read_data = 0.
- Accepted request with an error: memory is not modified. The next cycle gives rsp_valid = 1, rsp_err = 1, read_data = 0.
- Responses have no backpressure; the consumer must take them. One request per cycle at full throughput.
- Load of a word stored on the previous cycle returns the new value (write committed at the accept edge).
- req_valid while req_ready = 0 is ignored. Nothing is queued and no response is produced.

## Timing
- Reset (rst_n = 0 sampled at an edge):
  - Next state INIT with i = 0.
  - req_ready = 0, init_done = 0, rsp_valid = 0, rsp_err = 0, read_data = 0.
- Reset mid-INIT or mid-RUN: init restarts from word 0. Any response due in the following cycle is dropped (rsp_valid = 0). Memory contents are not guaranteed until init_done.
- Init latency: rst_n rises at edge E0. init_done and req_ready go to 1 after exactly DEPTH further edges, i.e. first visible in cycle DEPTH after release.
- Load/store latency: 1 cycle from the accept edge to the rsp_valid cycle.
- rsp_valid is a single-cycle pulse per request. read_data and rsp_err are held at 0 whenever rsp_valid = 0.
- Index values at or above 2^DATA_W wrap modulo 2^DATA_W during init.

## Configuration
- DMEM_BYTE_WRITE_EN defined:
  - Adds the byte_en port.
  - A store writes only the bytes whose strobe is 1.
  - A store with byte_en = 0 is legal: rsp_err = 0, no change to memory.
  - The alignment check is unchanged.
- DMEM_BYTE_WRITE_EN undefined: no byte_en port; every store writes the full word.

## Test plan
- Init: release reset with DEPTH = 256 -> init_done rises exactly 256 cycles later; loads of 0x0, 0x4 and 0x3FC return 0, 1 and 255.
- Store/load back-to-back: store 0xDEADBEEF at 0x10, then load 0x10 in the next cycle -> responses (err 0, data 0) then (err 0, data 0xDEADBEEF).
- Errors: load 0x402 -> rsp_err = 1 (misaligned); store 0x400 -> rsp_err = 1 (out of range); a following load of 0x0 returns 0, confirming no aliasing.
- Reset mid-run: assert rst_n = 0 in the cycle after a load is accepted -> no rsp_valid; init restarts, and word 0x10 reads 4 again after init_done.
- Byte write (DMEM_BYTE_WRITE_EN defined): word 0x20 holds 8; store 0xAABBCCDD with byte_en 4'b0101 -> load returns 0x00BB00DD.
- Ignored request: req_valid = 1 during INIT -> no rsp_valid; memory holds its init values.

Source files
------------

// File: rtl/dmem_sync.sv
// Clocked data memory with valid/ready request port and registered response.
// Optional per-byte store strobes when DMEM_BYTE_WRITE_EN is defined.
module dmem_sync #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   data_address,
  input  logic [DATA_W-1:0]   write_data,
`ifdef DMEM_BYTE_WRITE_EN
  input  logic [DATA_W/8-1:0] byte_en,
`endif
  output logic                rsp_valid,
  output logic                rsp_err,
  output logic [DATA_W-1:0]   read_data,
  output logic                init_done
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF   = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int HI    = OFF + IDX_W;
  localparam logic [ADDR_W-1:0] MIS_MASK =
    ADDR_W'((1 << OFF) - 1);
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(DEPTH - 1);

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_cnt;
  logic                r_ready;
  logic                r_done;
  logic                r_rsp_valid;
  logic                r_rsp_err;
  logic [DATA_W-1:0]   r_rdata;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_mis;
  logic                w_oor;
  logic                w_err;
  logic                w_acc;
  logic [IDX_W-1:0]    w_idx;
  logic [DATA_W-1:0]   w_wmask;
  logic                w_we;
  logic [IDX_W-1:0]    w_widx;
  logic [DATA_W-1:0]   w_wdata;

  assign w_mis = |(data_address & MIS_MASK);
  assign w_oor = |(data_address >> HI);
  assign w_err = w_mis | w_oor;
  assign w_idx = IDX_W'(data_address >> OFF);
  assign w_acc = req_valid & r_ready;

`ifdef DMEM_BYTE_WRITE_EN
  always_comb begin
    w_wmask = '0;
    for (int b = 0; b < NB; b++)
      w_wmask[b*8 +: 8] = {8{byte_en[b]}};
  end
`else
  assign w_wmask = '1;
`endif

  // Init sweep owns the write port until RUN
  always_comb begin
    w_we    = 1'b0;
    w_widx  = w_idx;
    w_wdata = (r_mem[w_idx] & ~w_wmask)
            | (write_data & w_wmask);
    if (!rst_n) begin
      w_we = 1'b0;
    end else if (r_state == INIT) begin
      w_we    = 1'b1;
      w_widx  = r_cnt;
      w_wdata = DATA_W'(r_cnt);
    end else if (w_acc && req_write && !w_err) begin
      w_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we)
      r_mem[w_widx] <= w_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= INIT;
      r_cnt       <= '0;
      r_ready     <= 1'b0;
      r_done      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_rsp_valid <= w_acc;
      r_rsp_err   <= w_acc & w_err;
      r_rdata     <= (w_acc && !req_write && !w_err)
                   ? r_mem[w_idx] : '0;
      unique case (r_state)
        INIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state <= RUN;
            r_ready <= 1'b1;
            r_done  <= 1'b1;
          end
        end
        RUN: begin
        end
      endcase
    end
  end

  assign req_ready = r_ready;
  assign init_done = r_done;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign read_data = r_rdata;

endmodule

// File: tb/tb_dmem_sync.sv
// Bench for dmem_sync: directed plan steps plus random traffic
// checked against an array model of the memory.
module tb_dmem_sync;

  localparam int DW = 32;
  localparam int DP = 256;
  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] data_address;
  logic [DW-1:0] write_data;
  logic [3:0]    byte_en;
  logic          rsp_valid;
  logic          rsp_err;
  logic [DW-1:0] read_data;
  logic          init_done;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] ref_mem [DP];

  always #5 clk = ~clk;

  dmem_sync #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .data_address (data_address),
    .write_data   (write_data),
`ifdef DMEM_BYTE_WRITE_EN
    .byte_en      (byte_en),
`endif
    .rsp_valid    (rsp_valid),
    .rsp_err      (rsp_err),
    .read_data    (read_data),
    .init_done    (init_done)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic ref_init();
    for (int i = 0; i < DP; i++)
      ref_mem[i] = i;
  endtask

  // One request; inputs stay driven so calls chain back-to-back
  task automatic do_req(input string tag, input bit w,
                        input logic [AW-1:0] a,
                        input logic [DW-1:0] d,
                        input logic [3:0] be);
    bit e;
    int idx;
    logic [DW-1:0] exp;
    logic [3:0] bev;
`ifdef DMEM_BYTE_WRITE_EN
    bev = be;
`else
    bev = 4'hF;
`endif
    e = (a % 4 != 0) || (int'(a) >= DP * 4);
    exp = '0;
    if (!e) begin
      idx = int'(a) / 4;
      if (!w)
        exp = ref_mem[idx];
      else
        for (int b = 0; b < 4; b++)
          if (bev[b]) ref_mem[idx][b*8 +: 8] = d[b*8 +: 8];
    end
    req_valid    = 1'b1;
    req_write    = w;
    data_address = a;
    write_data   = d;
    byte_en      = be;
    @(posedge clk); #1;
    chk({tag, ".vld"}, 32'(rsp_valid), 32'd1);
    chk({tag, ".err"}, 32'(rsp_err), 32'(e));
    chk({tag, ".data"}, read_data, exp);
  endtask

  task automatic idle(input string tag);
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk({tag, ".vld"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".err"}, 32'(rsp_err), 32'd0);
    chk({tag, ".data"}, read_data, 32'd0);
  endtask

  // Release reset and time init; a pending request must be ignored
  task automatic run_init(input string tag, input bit poke);
    bit seen;
    seen = 1'b0;
    req_valid    = poke;
    req_write    = 1'b1;
    data_address = 15'h10;
    write_data   = 32'h1234_5678;
    byte_en      = 4'hF;
    rst_n = 1'b1;
    for (int k = 1; k <= DP; k++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1'b1;
      if (k == DP - 1) begin
        chk({tag, ".done_early"}, 32'(init_done), 32'd0);
        chk({tag, ".rdy_early"}, 32'(req_ready), 32'd0);
      end
    end
    req_valid = 1'b0;
    chk({tag, ".done"}, 32'(init_done), 32'd1);
    chk({tag, ".rdy"}, 32'(req_ready), 32'd1);
    chk({tag, ".ignored"}, 32'(seen), 32'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    data_address = '0;
    write_data   = '0;
    byte_en      = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.rdy", 32'(req_ready), 32'd0);
    chk("rst.done", 32'(init_done), 32'd0);
    chk("rst.vld", 32'(rsp_valid), 32'd0);
    chk("rst.err", 32'(rsp_err), 32'd0);
    chk("rst.data", read_data, 32'd0);

    run_init("init", 1'b1);
    ref_init();
    do_req("ld0", 0, 15'h0, '0, 4'hF);
    do_req("ld4", 0, 15'h4, '0, 4'hF);
    do_req("ld3fc", 0, 15'h3FC, '0, 4'hF);
    idle("idle0");

    do_req("st10", 1, 15'h10, 32'hDEAD_BEEF, 4'hF);
    do_req("ld10", 0, 15'h10, '0, 4'hF);
    idle("idle1");

    do_req("mis", 0, 15'h402, '0, 4'hF);
    do_req("oor", 1, 15'h400, 32'hCAFE_F00D, 4'hF);
    do_req("alias", 0, 15'h0, '0, 4'hF);
    do_req("mis_st", 1, 15'h11, 32'h5555_AAAA, 4'hF);
    do_req("ld10b", 0, 15'h10, '0, 4'hF);
    idle("idle2");

`ifdef DMEM_BYTE_WRITE_EN
    do_req("ld20", 0, 15'h20, '0, 4'hF);
    do_req("bst", 1, 15'h20, 32'hAABB_CCDD, 4'b0101);
    do_req("bld", 0, 15'h20, '0, 4'hF);
    chk("bld.lit", read_data, 32'h00BB_00DD);
    do_req("bst0", 1, 15'h24, 32'hFFFF_FFFF, 4'b0000);
    do_req("bld0", 0, 15'h24, '0, 4'hF);
    idle("idle3");
`endif

    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] a;
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 6)
        a = AW'($urandom_range(0, 15) * 4);
      else if (sel < 8)
        a = AW'($urandom_range(0, DP - 1) * 4);
      else
        a = AW'($urandom);
      do_req("rnd", 1'($urandom), a, $urandom,
             4'($urandom));
      if ($urandom_range(0, 7) == 0) idle("rnd_idle");
    end
    idle("idle4");

    do_req("st10c", 1, 15'h10, 32'h0BAD_F00D, 4'hF);
    req_valid    = 1'b1;
    req_write    = 1'b0;
    data_address = 15'h10;
    rst_n        = 1'b0;
    @(posedge clk); #1;
    chk("mrst.vld", 32'(rsp_valid), 32'd0);
    chk("mrst.err", 32'(rsp_err), 32'd0);
    chk("mrst.data", read_data, 32'd0);
    chk("mrst.rdy", 32'(req_ready), 32'd0);
    chk("mrst.done", 32'(init_done), 32'd0);
    run_init("reinit", 1'b0);
    ref_init();
    do_req("ld10r", 0, 15'h10, '0, 4'hF);
    chk("ld10r.lit", read_data, 32'd4);
    do_req("ldffr", 0, 15'h3FC, '0, 4'hF);
    idle("idle5");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
